// File: rtl/core_addr_gen_if.sv
// core_addr_gen_if: start/enable handshake from the core controller plus the
// weight and image address beats going out to the BRAMs.
// master = controller side (drives start/enable/lengths), slave = sequencer.
interface core_addr_gen_if #(
  parameter int W_ADDR_WIDTH = 10,
  parameter int DIM_WIDTH    = 8,
  parameter int I_ADDR_WIDTH = 16
) ();
  // Controller -> sequencer
  logic                    start_core_in;
  logic                    en_core_in;
  logic [W_ADDR_WIDTH:0]   weight_len_in;
  logic [DIM_WIDTH-1:0]    img_rows_in;
  logic [DIM_WIDTH-1:0]    img_cols_in;

  // Sequencer -> BRAMs / controller
  logic [W_ADDR_WIDTH-1:0] weight_addr_out;
  logic                    weight_valid_out;
  logic                    weight_end_out;
  logic [I_ADDR_WIDTH-1:0] img_addr_out;
  logic                    img_valid_out;
  logic                    img_pad_out;
  logic                    img_end_out;
  logic                    busy_out;

  modport master (
    output start_core_in, en_core_in, weight_len_in, img_rows_in, img_cols_in,
    input  weight_addr_out, weight_valid_out, weight_end_out,
           img_addr_out, img_valid_out, img_pad_out, img_end_out, busy_out
  );

  modport slave (
    input  start_core_in, en_core_in, weight_len_in, img_rows_in, img_cols_in,
    output weight_addr_out, weight_valid_out, weight_end_out,
           img_addr_out, img_valid_out, img_pad_out, img_end_out, busy_out
  );
endinterface

// File: rtl/core_addr_gen.sv
// core_addr_gen: after a start pulse, streams weight-buffer read addresses
// 0..len-1, then image-buffer read addresses in row-major order, flagging the
// last beat of each phase. en_core_in low stalls everything in place.
// Optional build macro: CORE_ADDR_GEN_PAD_EN adds a one-pixel zero border
// around the image sweep ((rows+2)x(cols+2) beats, border beats flagged on
// img_pad_out with address 0). Without it the sweep is rows x cols and
// img_pad_out is constant 0.
module core_addr_gen #(
  parameter int W_ADDR_WIDTH = 10,
  parameter int DIM_WIDTH    = 8,
  parameter int I_ADDR_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active-low
  core_addr_gen_if.slave bus
);

  // Row/column counters carry one extra bit so the padded sweep can reach rows+1.
  localparam int CW = DIM_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WEIGHT = 2'd1,
    ST_IMAGE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [W_ADDR_WIDTH:0]   r_wlen;
  logic [W_ADDR_WIDTH:0]   w_wlen_next;
  logic [W_ADDR_WIDTH:0]   r_wcnt;
  logic [W_ADDR_WIDTH:0]   w_wcnt_next;
  logic [DIM_WIDTH-1:0]    r_rows;
  logic [DIM_WIDTH-1:0]    w_rows_next;
  logic [DIM_WIDTH-1:0]    r_cols;
  logic [DIM_WIDTH-1:0]    w_cols_next;
  logic [CW-1:0]           r_row;
  logic [CW-1:0]           w_row_next;
  logic [CW-1:0]           r_col;
  logic [CW-1:0]           w_col_next;
  logic [I_ADDR_WIDTH-1:0] r_row_base;
  logic [I_ADDR_WIDTH-1:0] w_row_base_next;

  logic                    w_wlen_zero;
  logic                    w_w_last;
  logic                    w_img_empty;
  logic                    w_row_last;
  logic                    w_col_last;
  logic [CW-1:0]           w_rows_ext;
  logic [CW-1:0]           w_cols_ext;
  logic [I_ADDR_WIDTH-1:0] w_img_addr;
  logic [I_ADDR_WIDTH-1:0] w_row_step;

  logic                    w_weight_valid;
  logic                    w_weight_end;
  logic                    w_img_valid;
  logic                    w_img_end;
  logic                    w_img_pad;

  assign w_rows_ext  = {1'b0, r_rows};
  assign w_cols_ext  = {1'b0, r_cols};
  assign w_wlen_zero = (r_wlen == '0);
  // Only meaningful when the length is non-zero; the zero case is handled separately.
  assign w_w_last    = (r_wcnt == (r_wlen - (W_ADDR_WIDTH+1)'(1)));
  assign w_img_empty = (r_rows == '0) || (r_cols == '0);

`ifdef CORE_ADDR_GEN_PAD_EN
  // Padded sweep: row/col run 0..rows+1 / 0..cols+1; the outer ring is border.
  logic w_border;
  assign w_row_last = (r_row == (w_rows_ext + CW'(1)));
  assign w_col_last = (r_col == (w_cols_ext + CW'(1)));
  assign w_border   = (r_row == '0) || (r_col == '0) || w_row_last || w_col_last;
  // row_base holds (row-1)*cols for interior rows, so interior address is
  // row_base + col - 1; border beats read nothing and present address 0.
  assign w_img_addr = w_border ? '0
                               : (r_row_base + I_ADDR_WIDTH'(r_col) - I_ADDR_WIDTH'(1));
  // The top border row contributes no image words, so its wrap adds nothing.
  assign w_row_step = (r_row == '0) ? '0 : I_ADDR_WIDTH'(r_cols);
`else
  assign w_row_last = (r_row == (w_rows_ext - CW'(1)));
  assign w_col_last = (r_col == (w_cols_ext - CW'(1)));
  assign w_img_addr = r_row_base + I_ADDR_WIDTH'(r_col);
  assign w_row_step = I_ADDR_WIDTH'(r_cols);
`endif

  // State, counters and latched lengths; reset clears everything to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wlen     <= '0;
      r_wcnt     <= '0;
      r_rows     <= '0;
      r_cols     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wlen     <= w_wlen_next;
      r_wcnt     <= w_wcnt_next;
      r_rows     <= w_rows_next;
      r_cols     <= w_cols_next;
      r_row      <= w_row_next;
      r_col      <= w_col_next;
      r_row_base <= w_row_base_next;
    end
  end

  // Next-state, counter advance and beat outputs; a stall (en low) holds all.
  always_comb begin
    w_state_next    = r_state;
    w_wlen_next     = r_wlen;
    w_wcnt_next     = r_wcnt;
    w_rows_next     = r_rows;
    w_cols_next     = r_cols;
    w_row_next      = r_row;
    w_col_next      = r_col;
    w_row_base_next = r_row_base;
    w_weight_valid  = 1'b0;
    w_weight_end    = 1'b0;
    w_img_valid     = 1'b0;
    w_img_end       = 1'b0;
    w_img_pad       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Lengths are captured only here, so a start during a run is ignored.
        if (bus.start_core_in) begin
          w_wlen_next     = bus.weight_len_in;
          w_rows_next     = bus.img_rows_in;
          w_cols_next     = bus.img_cols_in;
          w_wcnt_next     = '0;
          w_row_next      = '0;
          w_col_next      = '0;
          w_row_base_next = '0;
          w_state_next    = ST_WEIGHT;
        end
      end

      ST_WEIGHT: begin
        if (bus.en_core_in) begin
          w_weight_valid = !w_wlen_zero;
          w_weight_end   = w_wlen_zero || w_w_last;
          if (!w_wlen_zero) begin
            w_wcnt_next = r_wcnt + (W_ADDR_WIDTH+1)'(1);
          end
          // Image phase starts on the very next cycle: no bubble.
          if (w_weight_end) begin
            w_state_next = ST_IMAGE;
          end
        end
      end

      ST_IMAGE: begin
        if (bus.en_core_in) begin
          w_img_valid = !w_img_empty;
          w_img_end   = w_img_empty || (w_row_last && w_col_last);
`ifdef CORE_ADDR_GEN_PAD_EN
          w_img_pad   = !w_img_empty && w_border;
`endif
          if (!w_img_empty) begin
            if (w_col_last) begin
              // Row wrap: the base accumulates cols instead of multiplying.
              w_col_next      = '0;
              w_row_next      = r_row + CW'(1);
              w_row_base_next = r_row_base + w_row_step;
            end else begin
              w_col_next = r_col + CW'(1);
            end
          end
          if (w_img_end) begin
            w_state_next = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.weight_addr_out  = r_wcnt[W_ADDR_WIDTH-1:0];
  assign bus.weight_valid_out = w_weight_valid;
  assign bus.weight_end_out   = w_weight_end;
  assign bus.img_addr_out     = w_img_addr;
  assign bus.img_valid_out    = w_img_valid;
  assign bus.img_pad_out      = w_img_pad;
  assign bus.img_end_out      = w_img_end;
  assign bus.busy_out         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_core_addr_gen.sv
// tb_core_addr_gen: directed runs of core_addr_gen. A phase/beat-index model
// predicts every output on each falling edge; directed literals pin the model.
`timescale 1ns/1ps
module tb_core_addr_gen;
  localparam int WA = 10;
  localparam int DW = 8;
  localparam int IA = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_addr_gen_if #(.W_ADDR_WIDTH(WA), .DIM_WIDTH(DW), .I_ADDR_WIDTH(IA)) bus ();

  core_addr_gen #(.W_ADDR_WIDTH(WA), .DIM_WIDTH(DW), .I_ADDR_WIDTH(IA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase = 0;   // 0 idle, 1 weight, 2 image
  int m_wlen  = 0;
  int m_rows  = 0;
  int m_cols  = 0;
  int m_widx  = 0;
  int m_iidx  = 0;
  bit m_fresh = 1'b1;
  int e_n, e_wv, e_we, e_iv, e_ie, e_ip, e_busy, e_ia;
  bit e_pad;

  function automatic int img_total(input int rows, input int cols);
    if (rows == 0 || cols == 0) return 0;
`ifdef CORE_ADDR_GEN_PAD_EN
    return (rows + 2) * (cols + 2);
`else
    return rows * cols;
`endif
  endfunction

  // Address and pad flag of image beat k in row-major order.
  task automatic img_exp(input int k, input int rows, input int cols,
                         output int addr, output bit pad);
`ifdef CORE_ADDR_GEN_PAD_EN
    int w, r, c;
    w    = cols + 2;
    r    = k / w;
    c    = k % w;
    pad  = (r == 0) || (r == rows + 1) || (c == 0) || (c == cols + 1);
    addr = pad ? 0 : (r - 1) * cols + (c - 1);
`else
    pad  = 1'b0;
    addr = k;
`endif
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("rst_busy",    int'(bus.busy_out), 0);
      chk("rst_wvalid",  int'(bus.weight_valid_out), 0);
      chk("rst_wend",    int'(bus.weight_end_out), 0);
      chk("rst_waddr",   int'(bus.weight_addr_out), 0);
      chk("rst_ivalid",  int'(bus.img_valid_out), 0);
      chk("rst_iend",    int'(bus.img_end_out), 0);
      chk("rst_ipad",    int'(bus.img_pad_out), 0);
      chk("rst_iaddr",   int'(bus.img_addr_out), 0);
      m_phase = 0;
      m_fresh = 1'b1;
    end else begin
      e_n    = img_total(m_rows, m_cols);
      e_busy = int'(m_phase != 0);
      e_wv   = int'(m_phase == 1 && bus.en_core_in && m_wlen != 0);
      e_we   = int'(m_phase == 1 && bus.en_core_in && (m_wlen == 0 || m_widx == m_wlen - 1));
      e_iv   = int'(m_phase == 2 && bus.en_core_in && e_n != 0);
      e_ie   = int'(m_phase == 2 && bus.en_core_in && (e_n == 0 || m_iidx == e_n - 1));
      img_exp(m_iidx, m_rows, m_cols, e_ia, e_pad);
      e_ip   = int'(e_iv != 0 && e_pad);
      chk("m_busy",   int'(bus.busy_out), e_busy);
      chk("m_wvalid", int'(bus.weight_valid_out), e_wv);
      chk("m_wend",   int'(bus.weight_end_out), e_we);
      chk("m_ivalid", int'(bus.img_valid_out), e_iv);
      chk("m_iend",   int'(bus.img_end_out), e_ie);
      chk("m_ipad",   int'(bus.img_pad_out), e_ip);
      if (m_phase == 1 && m_wlen != 0) chk("m_waddr", int'(bus.weight_addr_out), m_widx);
      if (m_phase == 2 && e_n != 0)    chk("m_iaddr", int'(bus.img_addr_out), e_ia);
      if (m_phase == 0 && m_fresh) begin
        chk("m_idle_waddr", int'(bus.weight_addr_out), 0);
        chk("m_idle_iaddr", int'(bus.img_addr_out), 0);
      end
      // advance to what the next rising edge does
      if (m_phase == 0) begin
        if (bus.start_core_in) begin
          m_wlen  = int'(bus.weight_len_in);
          m_rows  = int'(bus.img_rows_in);
          m_cols  = int'(bus.img_cols_in);
          m_widx  = 0;
          m_iidx  = 0;
          m_phase = 1;
          m_fresh = 1'b0;
        end
      end else if (m_phase == 1 && bus.en_core_in) begin
        if (m_wlen == 0) m_phase = 2;
        else begin
          m_widx++;
          if (m_widx == m_wlen) m_phase = 2;
        end
      end else if (m_phase == 2 && bus.en_core_in) begin
        if (e_n != 0) m_iidx++;
        if (e_n == 0 || m_iidx == e_n) begin
          m_phase = 0;
          $display("run done: wlen=%0d rows=%0d cols=%0d img_beats=%0d (cycle %0d)",
                   m_wlen, m_rows, m_cols, m_iidx, cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int wl, input int r, input int c);
    bus.weight_len_in = (WA+1)'(wl);
    bus.img_rows_in   = DW'(r);
    bus.img_cols_in   = DW'(c);
    bus.start_core_in = 1'b1;
    tick();
    bus.start_core_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (!bus.busy_out) break;
      tick();
      k++;
    end
    if (k == budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", tag, budget);
    end
    tick();
  endtask

  // Literal expectations for weight_len=9, rows=4, cols=5, en high, no pad.
  task automatic check_basic(input string tag, input int c);
    if (c == 1) begin
      chk({tag, "_w0_valid"}, int'(bus.weight_valid_out), 1);
      chk({tag, "_w0_addr"},  int'(bus.weight_addr_out), 0);
    end
    if (c == 9) begin
      chk({tag, "_wend"},     int'(bus.weight_end_out), 1);
      chk({tag, "_wend_addr"}, int'(bus.weight_addr_out), 8);
    end
    if (c == 10) begin
      chk({tag, "_i0_valid"}, int'(bus.img_valid_out), 1);
      chk({tag, "_i0_addr"},  int'(bus.img_addr_out), 0);
    end
    if (c == 29) begin
      chk({tag, "_iend"},      int'(bus.img_end_out), 1);
      chk({tag, "_iend_addr"}, int'(bus.img_addr_out), 19);
    end
    if (c == 30) chk({tag, "_idle"}, int'(bus.busy_out), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start_core_in = 1'b0;
    bus.en_core_in    = 1'b1;
    bus.weight_len_in = '0;
    bus.img_rows_in   = '0;
    bus.img_cols_in   = '0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

`ifndef CORE_ADDR_GEN_PAD_EN
    // basic run
    start_run(9, 4, 5);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      check_basic("t1", c);
      tick();
    end

    // stalls at weight addr 4 and image addr 7
    start_run(9, 4, 5);
    for (int c = 1; c <= 36; c++) begin
      bus.en_core_in = !((c >= 5 && c <= 7) || (c >= 20 && c <= 22));
      @(negedge clk);
      if (c == 6) begin
        chk("t2_wstall_valid", int'(bus.weight_valid_out), 0);
        chk("t2_wstall_addr",  int'(bus.weight_addr_out), 4);
      end
      if (c == 8) begin
        chk("t2_wresume_valid", int'(bus.weight_valid_out), 1);
        chk("t2_wresume_addr",  int'(bus.weight_addr_out), 4);
      end
      if (c == 12) chk("t2_wend", int'(bus.weight_end_out), 1);
      if (c == 21) begin
        chk("t2_istall_valid", int'(bus.img_valid_out), 0);
        chk("t2_istall_end",   int'(bus.img_end_out), 0);
        chk("t2_istall_addr",  int'(bus.img_addr_out), 7);
      end
      if (c == 35) begin
        chk("t2_iend",      int'(bus.img_end_out), 1);
        chk("t2_iend_addr", int'(bus.img_addr_out), 19);
      end
      if (c == 36) chk("t2_idle", int'(bus.busy_out), 0);
      tick();
    end
    bus.en_core_in = 1'b1;

    // zero-length weight phase
    start_run(0, 2, 2);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("t3_wend",   int'(bus.weight_end_out), 1);
        chk("t3_wvalid", int'(bus.weight_valid_out), 0);
      end
      if (c == 2) begin
        chk("t3_i0_valid", int'(bus.img_valid_out), 1);
        chk("t3_i0_addr",  int'(bus.img_addr_out), 0);
      end
      if (c == 5) begin
        chk("t3_iend",      int'(bus.img_end_out), 1);
        chk("t3_iend_addr", int'(bus.img_addr_out), 3);
      end
      if (c == 6) chk("t3_idle", int'(bus.busy_out), 0);
      tick();
    end

    // reset in the middle of the image phase
    start_run(9, 4, 5);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      tick();
    end
    chk("t4_pre_addr", int'(bus.img_addr_out), 10);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_busy", int'(bus.busy_out), 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_after_busy", int'(bus.busy_out), 0);
    tick();
    start_run(9, 4, 5);
    @(negedge clk);
    chk("t4_restart_valid", int'(bus.weight_valid_out), 1);
    chk("t4_restart_addr",  int'(bus.weight_addr_out), 0);
    tick();
    wait_idle("t4_done", 40);

    // ignored mid-run start, then back-to-back restart in the idle cycle
    start_run(9, 4, 5);
    for (int c = 1; c <= 30; c++) begin
      if (c == 4) begin
        bus.start_core_in = 1'b1;
        bus.weight_len_in = (WA+1)'(3);
        bus.img_rows_in   = DW'(2);
        bus.img_cols_in   = DW'(2);
      end
      if (c == 5) bus.start_core_in = 1'b0;
      if (c == 30) begin
        bus.weight_len_in = (WA+1)'(9);
        bus.img_rows_in   = DW'(4);
        bus.img_cols_in   = DW'(5);
        bus.start_core_in = 1'b1;
      end
      @(negedge clk);
      check_basic("t5a", c);
      tick();
    end
    bus.start_core_in = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      check_basic("t5b", c);
      tick();
    end
`else
    // padded sweep: 6x7 positions, 22 of them border
    begin
      int nbeats = 0;
      int npad   = 0;
      start_run(9, 4, 5);
      for (int c = 1; c <= 52; c++) begin
        @(negedge clk);
        if (bus.img_valid_out) begin
          nbeats++;
          if (bus.img_pad_out) npad++;
        end
        if (c == 10) begin
          chk("p_corner_pad",  int'(bus.img_pad_out), 1);
          chk("p_corner_addr", int'(bus.img_addr_out), 0);
        end
        if (c == 18) begin
          chk("p_11_pad",  int'(bus.img_pad_out), 0);
          chk("p_11_addr", int'(bus.img_addr_out), 0);
        end
        if (c == 25) begin
          chk("p_21_pad",  int'(bus.img_pad_out), 0);
          chk("p_21_addr", int'(bus.img_addr_out), 5);
        end
        if (c == 51) begin
          chk("p_iend",     int'(bus.img_end_out), 1);
          chk("p_iend_pad", int'(bus.img_pad_out), 1);
        end
        if (c == 52) chk("p_idle", int'(bus.busy_out), 0);
        tick();
      end
      chk("p_beats", nbeats, 42);
      chk("p_pads",  npad, 22);
    end
`endif

    // empty image phase (rows=0)
    start_run(2, 0, 3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("t6_wend",      int'(bus.weight_end_out), 1);
        chk("t6_wend_addr", int'(bus.weight_addr_out), 1);
      end
      if (c == 3) begin
        chk("t6_iend",   int'(bus.img_end_out), 1);
        chk("t6_ivalid", int'(bus.img_valid_out), 0);
      end
      if (c == 4) chk("t6_idle", int'(bus.busy_out), 0);
      tick();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
